mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_pkg.sv | 43 ++++
 rtl/mul_seq_if.sv | 29 ++
 rtl/mul_step.sv | 26 ++
 rtl/mul_seq.sv | 139 +++++++++++++
 tb/tb_mul_seq.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types, constants and decode helpers for the sequential multiplier
package mul_pkg;

    localparam int CHUNK_W   = 8;
    localparam int MAX_ITERS = 4;

    // op encoding: bit0 accumulate, bit1 signed (long ops only), bit2 long
    typedef enum logic [2:0] {
        OP_MUL   = 3'b000,
        OP_MLA   = 3'b001,
        OP_UMULL = 3'b100,
        OP_UMLAL = 3'b101,
        OP_SMULL = 3'b110,
        OP_SMLAL = 3'b111
    } mul_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // Only UMULL/UMLAL are unsigned; short ops use signed arithmetic (low word is sign-agnostic)
    function automatic logic op_signed(input logic [2:0] op);
        return !(op[2] && !op[1]);
    endfunction

    // Smallest chunk count whose value already represents rs exactly
    function automatic logic [2:0] early_iters(input logic [2:0] op, input logic [31:0] rs);
        if (!op_signed(op)) begin
            if (rs[31:8] == '0)       return 3'd1;
            else if (rs[31:16] == '0) return 3'd2;
            else if (rs[31:24] == '0) return 3'd3;
            else                      return 3'd4;
        end else begin
            if ((&rs[31:7]) || (rs[31:7] == '0))        return 3'd1;
            else if ((&rs[31:15]) || (rs[31:15] == '0)) return 3'd2;
            else if ((&rs[31:23]) || (rs[31:23] == '0)) return 3'd3;
            else                                        return 3'd4;
        end
    endfunction

endpackage

// File: rtl/mul_seq_if.sv
// rtl/mul_seq_if.sv - request/result bundle between a requester and mul_seq
interface mul_seq_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [31:0] acc_lo;
    logic [31:0] acc_hi;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic        flag_n;
    logic        flag_z;
    logic [2:0]  iters;

    modport master (
        output start, op, rm, rs, acc_lo, acc_hi, flush,
        input  busy, done, res_lo, res_hi, flag_n, flag_z, iters
    );

    modport slave (
        input  start, op, rm, rs, acc_lo, acc_hi, flush,
        output busy, done, res_lo, res_hi, flag_n, flag_z, iters
    );

endinterface

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one 8x32 partial product accumulated into a 64-bit running sum
module mul_step (
    input  logic [63:0] psum_i,
    input  logic [31:0] rm_i,
    input  logic [7:0]  chunk_i,
    input  logic [1:0]  idx_i,
    input  logic        rm_signed_i,
    input  logic        chunk_signed_i,
    output logic [63:0] psum_o
);

    logic signed [41:0] a;
    logic signed [41:0] b;
    logic signed [41:0] p;
    logic        [63:0] p_ext;

    // The final chunk of a signed multiplier carries the sign, so it is treated as two's complement
    always_comb begin
        a      = {{10{rm_signed_i & rm_i[31]}}, rm_i};
        b      = {{34{chunk_signed_i & chunk_i[7]}}, chunk_i};
        p      = a * b;
        p_ext  = {{22{p[41]}}, p};
        psum_o = psum_i + (p_ext << {idx_i, 3'b000});
    end

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential 32x32 multiplier, 8 multiplier bits per cycle; MUL_SEQ_EARLY_TERM_EN enables early termination
module mul_seq
    import mul_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    mul_seq_if.slave bus
);

    mul_state_t  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] rm_q, rm_d;
    logic [31:0] rs_q, rs_d;
    logic [63:0] psum_q, psum_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic        flag_n_q, flag_n_d;
    logic        flag_z_q, flag_z_d;
    logic [2:0]  iters_q, iters_d;

    logic [2:0]  n_iters;
    logic        last;
    logic [7:0]  chunk;
    logic [63:0] step_sum;

`ifdef MUL_SEQ_EARLY_TERM_EN
    assign n_iters = early_iters(op_q, rs_q);
`else
    assign n_iters = 3'(MAX_ITERS);
`endif

    assign last  = (({1'b0, idx_q} + 3'd1) == n_iters);
    assign chunk = rs_q[idx_q*CHUNK_W +: CHUNK_W];

    mul_step u_step (
        .psum_i         (psum_q),
        .rm_i           (rm_q),
        .chunk_i        (chunk),
        .idx_i          (idx_q),
        .rm_signed_i    (op_signed(op_q)),
        .chunk_signed_i (op_signed(op_q) && last),
        .psum_o         (step_sum)
    );

    // State and datapath registers; reset clears everything and drops any op in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            rm_q     <= '0;
            rs_q     <= '0;
            psum_q   <= '0;
            idx_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            iters_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rm_q     <= rm_d;
            rs_q     <= rs_d;
            psum_q   <= psum_d;
            idx_q    <= idx_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
            iters_q  <= iters_d;
        end
    end

    // Next state: accept from IDLE/DONE, iterate in CALC, publish results only on the final step
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rm_d     = rm_q;
        rs_d     = rs_q;
        psum_d   = psum_q;
        idx_d    = idx_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        iters_d  = iters_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_CALC;
                    op_d    = bus.op;
                    rm_d    = bus.rm;
                    rs_d    = bus.rs;
                    idx_d   = '0;
                    if (!bus.op[0])     psum_d = '0;
                    else if (bus.op[2]) psum_d = {bus.acc_hi, bus.acc_lo};
                    else                psum_d = {32'd0, bus.acc_lo};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    psum_d = step_sum;
                    idx_d  = idx_q + 2'd1;
                    if (last) begin
                        state_d = ST_DONE;
                        iters_d = n_iters;
                        if (op_q[2]) begin
                            res_lo_d = step_sum[31:0];
                            res_hi_d = step_sum[63:32];
                            flag_n_d = step_sum[63];
                            flag_z_d = (step_sum == '0);
                        end else begin
                            res_lo_d = step_sum[31:0];
                            res_hi_d = '0;
                            flag_n_d = step_sum[31];
                            flag_z_d = (step_sum[31:0] == '0);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy   = (state_q == ST_CALC);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.res_lo = res_lo_q;
    assign bus.res_hi = res_hi_q;
    assign bus.flag_n = flag_n_q;
    assign bus.flag_z = flag_z_q;
    assign bus.iters  = iters_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq; expectations follow MUL_SEQ_EARLY_TERM_EN
module tb_mul_seq;
    import mul_pkg::*;

`ifdef MUL_SEQ_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_seq_if bus ();
    mul_seq dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: acc + rm*rs in 64-bit arithmetic, iteration count from the magnitude of rs
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] rm, rs, alo, ahi,
                                      output logic [31:0] lo, hi, output logic fn, fz, output int it);
        logic [63:0] prod, acc, r;
        longint      s, lim;
        bit          uns;
        uns = op[2] && !op[1];
        if (uns) prod = {32'd0, rm} * {32'd0, rs};
        else     prod = longint'($signed(rm)) * longint'($signed(rs));
        if (!op[0])     acc = 64'd0;
        else if (op[2]) acc = {ahi, alo};
        else            acc = {32'd0, alo};
        r = prod + acc;
        if (op[2]) begin
            lo = r[31:0]; hi = r[63:32]; fn = r[63]; fz = (r == 64'd0);
        end else begin
            lo = r[31:0]; hi = 32'd0; fn = r[31]; fz = (r[31:0] == 32'd0);
        end
        it = 4;
        if (ET) begin
            s = longint'($signed(rs));
            for (int k = 3; k >= 1; k--) begin
                lim = longint'(1) << (8 * k - 1);
                if (uns ? ({32'd0, rs} < (64'd1 << (8 * k))) : (s >= -lim && s < lim)) it = k;
            end
        end
    endfunction

    // Called one step after an accepting edge; counts cycles until done (start cycle = 0)
    task automatic wait_done(output int cyc, output bit to);
        cyc = 1;
        to  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rm, rs, alo, ahi,
                         output int cyc, output bit to);
        bus.start = 1'b1; bus.op = op; bus.rm = rm; bus.rs = rs;
        bus.acc_lo = alo; bus.acc_hi = ahi;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(cyc, to);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.flag_n, bus.flag_z, bus.iters} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got busy=%b done=%b n=%b z=%b iters=%0d, want all 0",
                     bus.busy, bus.done, bus.flag_n, bus.flag_z, bus.iters);
        end
        n_cmp++;
        if ({bus.res_hi, bus.res_lo} !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_res: got %h_%h, want 0", bus.res_hi, bus.res_lo);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        int cyc; bit to;
        issue(OP_MUL, 32'd3, 32'd5, 32'd0, 32'd0, cyc, to);
        n_cmp++;
        if (to || bus.res_lo !== 32'd15 || bus.res_hi !== 32'd0 || bus.iters !== (ET ? 3'd1 : 3'd4)
            || cyc != (ET ? 2 : 5)) begin
            n_bad++;
            $display("FAIL mul_3x5: got lo=%0d hi=%0d iters=%0d cyc=%0d to=%b, want 15 0 %0d %0d",
                     bus.res_lo, bus.res_hi, bus.iters, cyc, to, ET ? 1 : 4, ET ? 2 : 5);
        end
        issue(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, cyc, to);
        n_cmp++;
        if (to || bus.res_hi !== 32'hFFFF_FFFE || bus.res_lo !== 32'h0000_0001 || bus.flag_n !== 1'b1
            || bus.flag_z !== 1'b0 || bus.iters !== 3'd4 || cyc != 5) begin
            n_bad++;
            $display("FAIL umull_max: got %h_%h n=%b z=%b iters=%0d cyc=%0d, want fffffffe_00000001 1 0 4 5",
                     bus.res_hi, bus.res_lo, bus.flag_n, bus.flag_z, bus.iters, cyc);
        end
        issue(OP_SMLAL, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFF0, 32'd0, cyc, to);
        n_cmp++;
        if (to || bus.res_hi !== 32'd0 || bus.res_lo !== 32'hFFFF_FFF6 || bus.flag_n !== 1'b0
            || bus.iters !== (ET ? 3'd1 : 3'd4)) begin
            n_bad++;
            $display("FAIL smlal_neg: got %h_%h n=%b iters=%0d, want 00000000_fffffff6 0 %0d",
                     bus.res_hi, bus.res_lo, bus.flag_n, bus.iters, ET ? 1 : 4);
        end
        issue(OP_MLA, 32'd0, 32'h1234_5678, 32'd0, 32'hDEAD_BEEF, cyc, to);
        n_cmp++;
        if (to || bus.res_lo !== 32'd0 || bus.res_hi !== 32'd0 || bus.flag_z !== 1'b1
            || bus.flag_n !== 1'b0 || bus.iters !== 3'd4) begin
            n_bad++;
            $display("FAIL mla_zero: got %h_%h z=%b n=%b iters=%0d, want 0 0 z=1 n=0 4",
                     bus.res_hi, bus.res_lo, bus.flag_z, bus.flag_n, bus.iters);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int cyc, it; bit to;
        logic [2:0] op; logic [31:0] rm, rs, alo, ahi, lo, hi; logic fn, fz;
        for (int t = 0; t < 40; t++) begin
            op  = 3'($urandom_range(0, 7));
            rm  = $urandom;
            rs  = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rs = ~rs;
            alo = $urandom;
            ahi = $urandom;
            ref_model(op, rm, rs, alo, ahi, lo, hi, fn, fz, it);
            issue(op, rm, rs, alo, ahi, cyc, to);
            n_cmp++;
            if (to || bus.res_lo !== lo || bus.res_hi !== hi || bus.flag_n !== fn || bus.flag_z !== fz
                || bus.iters !== 3'(it) || cyc != it + 1) begin
                n_bad++;
                $display("FAIL random[%0d] op=%b rm=%h rs=%h: got %h_%h n=%b z=%b it=%0d cyc=%0d to=%b, want %h_%h n=%b z=%b it=%0d cyc=%0d",
                         t, op, rm, rs, bus.res_hi, bus.res_lo, bus.flag_n, bus.flag_z, bus.iters, cyc, to,
                         hi, lo, fn, fz, it, it + 1);
            end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc, it_a, it_b; bit to;
        logic [31:0] lo_a, hi_a, lo_b, hi_b; logic fn, fz;
        ref_model(3'b110, 32'h8000_0001, 32'h0000_1234, 32'd0, 32'd0, lo_a, hi_a, fn, fz, it_a);
        ref_model(3'b101, 32'h0001_0003, 32'h0000_0077, 32'h1111_1111, 32'h2222_2222, lo_b, hi_b, fn, fz, it_b);
        bus.start = 1'b1; bus.op = 3'b110; bus.rm = 32'h8000_0001; bus.rs = 32'h0000_1234;
        bus.acc_lo = 32'd0; bus.acc_hi = 32'd0;
        @(posedge clk); #1;
        wait_done(cyc, to);
        n_cmp++;
        if (to || {bus.res_hi, bus.res_lo} !== {hi_a, lo_a} || cyc != it_a + 1) begin
            n_bad++;
            $display("FAIL b2b_first: got %h_%h cyc=%0d to=%b, want %h_%h cyc=%0d",
                     bus.res_hi, bus.res_lo, cyc, to, hi_a, lo_a, it_a + 1);
        end
        bus.op = 3'b101; bus.rm = 32'h0001_0003; bus.rs = 32'h0000_0077;
        bus.acc_lo = 32'h1111_1111; bus.acc_hi = 32'h2222_2222;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", bus.busy, bus.done);
        end
        wait_done(cyc, to);
        n_cmp++;
        if (to || {bus.res_hi, bus.res_lo} !== {hi_b, lo_b} || cyc != it_b + 1) begin
            n_bad++;
            $display("FAIL b2b_second: got %h_%h cyc=%0d to=%b, want %h_%h cyc=%0d",
                     bus.res_hi, bus.res_lo, cyc, to, hi_b, lo_b, it_b + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_idle_start();
        int cyc, it; bit to;
        logic [31:0] lo, hi; logic fn, fz;
        ref_model(3'b001, 32'h0000_0101, 32'h0000_0202, 32'h0000_0010, 32'd0, lo, hi, fn, fz, it);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'b001; bus.rm = 32'h0000_0101;
        bus.rs = 32'h0000_0202; bus.acc_lo = 32'h0000_0010; bus.acc_hi = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_start_idle: got busy=%b, want 1", bus.busy);
        end
        wait_done(cyc, to);
        n_cmp++;
        if (to || bus.res_lo !== lo || bus.res_hi !== hi || cyc != it + 1) begin
            n_bad++;
            $display("FAIL flush_start_result: got %h_%h cyc=%0d to=%b, want %h_%h cyc=%0d",
                     bus.res_hi, bus.res_lo, cyc, to, hi, lo, it + 1);
        end
    endtask

    task automatic test_flush_reset();
        int cyc, it, dones; bit to;
        logic [31:0] lo, hi; logic fn, fz;
        ref_model(3'b000, 32'd7, 32'd9, 32'd0, 32'd0, lo, hi, fn, fz, it);
        issue(3'b000, 32'd7, 32'd9, 32'd0, 32'd0, cyc, to);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'b100; bus.rm = 32'hCAFE_F00D; bus.rs = 32'h1234_5678;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.res_lo !== lo || bus.res_hi !== hi
            || bus.iters !== 3'(it) || bus.flag_n !== fn || bus.flag_z !== fz) begin
            n_bad++;
            $display("FAIL flush_hold: got busy=%b done=%b %h_%h it=%0d, want 0 0 %h_%h it=%0d",
                     bus.busy, bus.done, bus.res_hi, bus.res_lo, bus.iters, hi, lo, it);
        end
        dones = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_bad++;
            $display("FAIL flush_no_done: got %0d done pulses, want 0", dones);
        end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.res_lo !== lo || bus.res_hi !== hi) begin
            n_bad++;
            $display("FAIL midcalc_hold: got busy=%b %h_%h, want 1 %h_%h", bus.busy, bus.res_hi, bus.res_lo, hi, lo);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.flag_n, bus.flag_z, bus.iters} !== 7'd0
            || {bus.res_hi, bus.res_lo} !== 64'd0) begin
            n_bad++;
            $display("FAIL async_reset: got busy=%b done=%b %h_%h n=%b z=%b it=%0d, want all 0",
                     bus.busy, bus.done, bus.res_hi, bus.res_lo, bus.flag_n, bus.flag_z, bus.iters);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_bad++;
            $display("FAIL reset_discard: got %0d busy/done cycles after reset, want 0", dones);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0;
        bus.rm = 32'd0; bus.rs = 32'd0; bus.acc_lo = 32'd0; bus.acc_hi = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush_idle_start();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
